// File: rtl/ajuste_hora_ctrl.sv
// Time-set controller: MODE cycles RUN -> SET_H -> SET_M, INC steps the selected field.
// Optional auto-repeat on held INC is built only when AUTO_REPEAT_EN is defined.
module ajuste_hora_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned HOLD_CYC     = 25_000_000,
  parameter int unsigned REPEAT_CYC   = 5_000_000,
  parameter int unsigned TIMEOUT_S    = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       tick_1hz,
  output logic       run_en,
  output logic       seg_zera,
  output logic       inc_hora,
  output logic       inc_min,
  output logic       blank_h,
  output logic       blank_m,
  output logic [1:0] modo
);

  localparam int unsigned TO_W = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_SET_H = 2'b01,
    ST_SET_M = 2'b10
  } state_t;

  state_t          state;
  logic [TO_W-1:0] tcnt;
  logic            phase;
  logic            mode_lvl, mode_lvl_d, inc_lvl, inc_lvl_d;
  logic            mode_ev, inc_ev, in_set, timeout_c, inc_ok, rep_ok, step;

  ajuste_hora_debounce #(.STABLE_CYC(DEBOUNCE_CYC)) u_deb_mode (
    .clock (clock),
    .reset (reset),
    .btn   (btn_mode),
    .level (mode_lvl)
  );

  ajuste_hora_debounce #(.STABLE_CYC(DEBOUNCE_CYC)) u_deb_inc (
    .clock (clock),
    .reset (reset),
    .btn   (btn_inc),
    .level (inc_lvl)
  );

  // Rising edge of the debounced levels; release produces no event
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_lvl_d <= 1'b0;
      inc_lvl_d  <= 1'b0;
    end else begin
      mode_lvl_d <= mode_lvl;
      inc_lvl_d  <= inc_lvl;
    end
  end

  assign mode_ev   = mode_lvl & ~mode_lvl_d;
  assign inc_ev    = inc_lvl & ~inc_lvl_d;
  assign in_set    = (state != ST_RUN);
  assign timeout_c = in_set && (tcnt == TO_W'(TIMEOUT_S));
  // MODE and timeout both pre-empt an INC landing in the same cycle
  assign inc_ok    = inc_ev & ~mode_ev & in_set & ~timeout_c;
  assign step      = inc_ok | rep_ok;
  assign modo      = state;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RP_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

  logic            armed, first_gap, rep_ev;
  logic [RP_W-1:0] rcnt;

  assign rep_ev = armed && inc_lvl &&
                  (rcnt == (first_gap ? RP_W'(HOLD_CYC - 1) : RP_W'(REPEAT_CYC - 1)));
  assign rep_ok = rep_ev & ~mode_ev & in_set & ~timeout_c;

  // Armed by an accepted press; dropped on release, MODE, timeout or leaving SET
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed     <= 1'b0;
      first_gap <= 1'b0;
      rcnt      <= '0;
    end else if (inc_ok) begin
      armed     <= 1'b1;
      first_gap <= 1'b1;
      rcnt      <= '0;
    end else if (armed) begin
      if (!inc_lvl || mode_ev || timeout_c || !in_set) begin
        armed <= 1'b0;
        rcnt  <= '0;
      end else if (rep_ok) begin
        first_gap <= 1'b0;
        rcnt      <= '0;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = |{32'(HOLD_CYC), 32'(REPEAT_CYC)};
  assign rep_ok = 1'b0;
`endif

  // Mode FSM with registered pulse and blanking outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      tcnt     <= '0;
      phase    <= 1'b0;
      run_en   <= 1'b1;
      seg_zera <= 1'b0;
      inc_hora <= 1'b0;
      inc_min  <= 1'b0;
      blank_h  <= 1'b0;
      blank_m  <= 1'b0;
    end else begin
      seg_zera <= 1'b0;
      inc_hora <= 1'b0;
      inc_min  <= 1'b0;
      case (state)
        ST_RUN: begin
          tcnt  <= '0;
          phase <= 1'b0;
          if (mode_ev) begin
            state    <= ST_SET_H;
            run_en   <= 1'b0;
            seg_zera <= 1'b1;
          end
        end
        default: begin
          if (mode_ev || timeout_c) begin
            tcnt    <= '0;
            phase   <= 1'b0;
            blank_h <= 1'b0;
            blank_m <= 1'b0;
            if (mode_ev && state == ST_SET_H) begin
              state <= ST_SET_M;
            end else begin
              state  <= ST_RUN;
              run_en <= 1'b1;
            end
          end else if (step) begin
            inc_hora <= (state == ST_SET_H);
            inc_min  <= (state == ST_SET_M);
            tcnt     <= '0;
            phase    <= 1'b0;
            blank_h  <= 1'b0;
            blank_m  <= 1'b0;
          end else if (tick_1hz) begin
            tcnt    <= tcnt + 1'b1;
            phase   <= ~phase;
            blank_h <= (state == ST_SET_H) & ~phase;
            blank_m <= (state == ST_SET_M) & ~phase;
          end
        end
      endcase
    end
  end

endmodule

// Two-flop synchronizer followed by a stable-sample debouncer
module ajuste_hora_debounce #(
  parameter int unsigned STABLE_CYC = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic level
);

  localparam int unsigned CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Level flips only after STABLE_CYC consecutive samples that disagree with it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(STABLE_CYC - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ajuste_hora_ctrl.sv
// Scoreboard bench for ajuste_hora_ctrl: stimulus queues expected output vectors,
// a monitor compares every observed output change against the queue head.
module tb_ajuste_hora_ctrl;

  localparam int unsigned DEBOUNCE_CYC = 4;
  localparam int unsigned HOLD_CYC     = 20;
  localparam int unsigned REPEAT_CYC   = 8;
  localparam int unsigned TIMEOUT_S    = 3;

  // {seg_zera, inc_hora, inc_min, run_en, blank_h, blank_m, modo}
  localparam logic [7:0] V_RUN    = 8'b0001_0000;
  localparam logic [7:0] V_ENT_H  = 8'b1000_0001;
  localparam logic [7:0] V_SET_H  = 8'b0000_0001;
  localparam logic [7:0] V_INC_H  = 8'b0100_0001;
  localparam logic [7:0] V_SET_M  = 8'b0000_0010;
  localparam logic [7:0] V_INC_M  = 8'b0010_0010;
  localparam logic [7:0] V_BLK_M  = 8'b0000_0110;

  logic       clock = 1'b0;
  logic       reset, btn_mode, btn_inc, tick_1hz;
  logic       run_en, seg_zera, inc_hora, inc_min, blank_h, blank_m;
  logic [1:0] modo;
  logic [7:0] obs;

  typedef struct {
    logic [7:0] vec;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  ajuste_hora_ctrl #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .HOLD_CYC     (HOLD_CYC),
    .REPEAT_CYC   (REPEAT_CYC),
    .TIMEOUT_S    (TIMEOUT_S)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .tick_1hz (tick_1hz),
    .run_en   (run_en),
    .seg_zera (seg_zera),
    .inc_hora (inc_hora),
    .inc_min  (inc_min),
    .blank_h  (blank_h),
    .blank_m  (blank_m),
    .modo     (modo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign obs = {seg_zera, inc_hora, inc_min, run_en, blank_h, blank_m, modo};

  task automatic expect_out(input logic [7:0] v, input int gap);
    exp_t e;
    e.vec = v;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step(10);
    btn_mode = 1'b0;
    step(12);
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    step(10);
    btn_inc = 1'b0;
    step(12);
  endtask

  task automatic press_both();
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    step(10);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(12);
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
    step(5);
  endtask

  // Monitor: every change of the output vector is one scoreboard comparison
  initial begin
    logic [7:0] prev;
    int         last;
    exp_t       e;
    prev = 8'hxx;
    last = 0;
    forever begin
      @(negedge clock);
      if (obs !== prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: got %b at cycle %0d, nothing expected", obs, cyc);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e.vec || (e.gap >= 0 && (cyc - last) != e.gap)) begin
            fails++;
            $display("FAIL out_seq: got %b after %0d cycles, expected %b after %0d",
                     obs, cyc - last, e.vec, e.gap);
          end
        end
        prev = obs;
        last = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset    = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick_1hz = 1'b0;
    expect_out(V_RUN, -1);
    #2;
    check("reset_state", obs, V_RUN);
    step(3);
    reset = 1'b0;
    step(5);

    // Bouncing MODE: only the final stable press counts
    expect_out(V_ENT_H, -1);
    expect_out(V_SET_H, 1);
    repeat (5) begin
      btn_mode = 1'b1;
      step(3);
      btn_mode = 1'b0;
      step(2);
    end
    press_mode();

    // Three hour increments, then minutes
    repeat (3) begin
      expect_out(V_INC_H, -1);
      expect_out(V_SET_H, 1);
      press_inc();
    end
    expect_out(V_SET_M, -1);
    press_mode();
    repeat (2) begin
      expect_out(V_INC_M, -1);
      expect_out(V_SET_M, 1);
      press_inc();
    end

    // Timeout in SET_M with minute blinking
    expect_out(V_BLK_M, -1);
    expect_out(V_SET_M, -1);
    expect_out(V_BLK_M, -1);
    expect_out(V_RUN, 1);
    repeat (3) pulse_tick();
    step(4);

    // Simultaneous MODE and INC in SET_H: MODE wins
    expect_out(V_ENT_H, -1);
    expect_out(V_SET_H, 1);
    press_mode();
    expect_out(V_SET_M, -1);
    press_both();
    expect_out(V_RUN, -1);
    press_mode();

    // Held INC in SET_H
    expect_out(V_ENT_H, -1);
    expect_out(V_SET_H, 1);
    press_mode();
    expect_out(V_INC_H, -1);
    expect_out(V_SET_H, 1);
`ifdef AUTO_REPEAT_EN
    expect_out(V_INC_H, 19);
    expect_out(V_SET_H, 1);
    repeat (3) begin
      expect_out(V_INC_H, 7);
      expect_out(V_SET_H, 1);
    end
`endif
    btn_inc = 1'b1;
    step(48);
    btn_inc = 1'b0;
    step(12);
    expect_out(V_SET_M, -1);
    press_mode();
    expect_out(V_RUN, -1);
    press_mode();

    // Reset in SET_M while INC is held
    expect_out(V_ENT_H, -1);
    expect_out(V_SET_H, 1);
    press_mode();
    expect_out(V_SET_M, -1);
    press_mode();
    expect_out(V_INC_M, -1);
    expect_out(V_SET_M, 1);
    btn_inc = 1'b1;
    step(15);
    expect_out(V_RUN, -1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_mid_set", obs, V_RUN);
    step(3);
    reset = 1'b0;
    step(20);
    expect_out(V_ENT_H, -1);
    expect_out(V_SET_H, 1);
    press_mode();
    btn_inc = 1'b0;
    step(12);
    expect_out(V_INC_H, -1);
    expect_out(V_SET_H, 1);
    press_inc();
    expect_out(V_SET_M, -1);
    press_mode();
    expect_out(V_RUN, -1);
    press_mode();

    step(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_output: expected %b never observed", e.vec);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
